// File: rtl/shared_bank_port_client.sv
// Per-port client of the shared VC banks: tracks bank ownership with one FSM per bank
// and hands out free shared VCs of owned banks in round-robin order.
module shared_bank_port_client #(
    parameter int num_banks        = 2,
    parameter int num_vcs_per_bank = 2,
    parameter int num_ports        = 5,
    parameter int port_id          = 0,
    parameter int vc_idx_width     = 2
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic [num_banks*num_ports-1:0]         bank_grant,
    input  logic [num_banks-1:0]                   bank_ready,
    input  logic                                   vc_req,
    output logic                                   vc_gnt,
    output logic [vc_idx_width-1:0]                vc_gnt_id,
    input  logic [num_banks*num_vcs_per_bank-1:0]  vc_release,
    output logic [num_banks*num_vcs_per_bank-1:0]  vc_busy,
    output logic [num_banks-1:0]                   bank_in_use,
    output logic [num_banks-1:0]                   bank_owned,
    output logic                                   protocol_error
);
    // state    | meaning
    // IDLE     | bank not held by this port
    // OWNED    | bank granted and ready; its free VCs may be allocated
    // DRAINING | ownership lost; waiting for the bank's busy VCs to release
    typedef enum logic [1:0] {IDLE, OWNED, DRAINING} bank_state_t;

    localparam int total_vcs = num_banks * num_vcs_per_bank;
    localparam int cw        = vc_idx_width + 1;
    localparam logic [vc_idx_width-1:0] last_idx = vc_idx_width'(total_vcs - 1);

    bank_state_t state_q [num_banks];
    bank_state_t state_d [num_banks];

    logic [vc_idx_width-1:0] rr_ptr;
    logic [total_vcs-1:0]    vc_alloc;
    logic [total_vcs-1:0]    busy_after_rel;
    logic [total_vcs-1:0]    gnt_onehot;
    logic [cw-1:0]           scan;
    logic                    sel_found;

    for (genvar v = 0; v < total_vcs; v++) begin : g_alloc
        assign vc_alloc[v] = (state_q[v / num_vcs_per_bank] == OWNED) && !vc_busy[v];
    end

    for (genvar b = 0; b < num_banks; b++) begin : g_bank_out
        assign bank_in_use[b] = |vc_busy[b*num_vcs_per_bank +: num_vcs_per_bank];
        assign bank_owned[b]  = (state_q[b] == OWNED);
    end

    // First allocatable index at or after rr_ptr, wrapping at total_vcs.
    always_comb begin
        sel_found = 1'b0;
        vc_gnt_id = '0;
        scan      = '0;
        for (int i = 0; i < total_vcs; i++) begin
            scan = {1'b0, rr_ptr} + cw'(i);
            if (scan >= cw'(total_vcs)) begin
                scan = scan - cw'(total_vcs);
            end
            if (!sel_found && vc_alloc[scan[vc_idx_width-1:0]]) begin
                sel_found = 1'b1;
                vc_gnt_id = scan[vc_idx_width-1:0];
            end
        end
        vc_gnt     = vc_req && sel_found;
        gnt_onehot = '0;
        if (vc_gnt) begin
            gnt_onehot[vc_gnt_id] = 1'b1;
        end
    end

    assign busy_after_rel = vc_busy & ~vc_release;

    // Only OWNED banks can receive a grant, so draining banks look at releases alone.
    always_comb begin
        for (int b = 0; b < num_banks; b++) begin
            state_d[b] = state_q[b];
            case (state_q[b])
                IDLE: begin
                    if (bank_grant[b*num_ports + port_id] && bank_ready[b]) begin
                        state_d[b] = OWNED;
                    end
                end
                OWNED: begin
                    if (!bank_grant[b*num_ports + port_id] || !bank_ready[b]) begin
                        state_d[b] = DRAINING;
                    end
                end
                DRAINING: begin
                    if (busy_after_rel[b*num_vcs_per_bank +: num_vcs_per_bank] == '0) begin
                        state_d[b] = IDLE;
                    end
                end
                default: state_d[b] = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int b = 0; b < num_banks; b++) begin
                state_q[b] <= IDLE;
            end
            vc_busy        <= '0;
            rr_ptr         <= '0;
            protocol_error <= 1'b0;
        end else begin
            for (int b = 0; b < num_banks; b++) begin
                state_q[b] <= state_d[b];
            end
            vc_busy <= busy_after_rel | gnt_onehot;
            if (vc_gnt) begin
                rr_ptr <= (vc_gnt_id == last_idx) ? '0 : vc_gnt_id + 1'b1;
            end
            if (|(vc_release & ~vc_busy)) begin
                protocol_error <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_shared_bank_port_client.sv
// Scoreboard bench for shared_bank_port_client: expectations are queued as stimulus is
// applied and popped against the DUT outputs once they are due.
module tb_shared_bank_port_client;
    localparam int SIG_GNT = 0, SIG_ID = 1, SIG_BUSY = 2, SIG_INUSE = 3, SIG_OWNED = 4, SIG_PERR = 5;

    typedef struct {
        string       tag;
        int          sig;
        logic [31:0] exp;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [9:0] bank_grant;
    logic [1:0] bank_ready;
    logic       vc_req;
    logic       vc_gnt;
    logic [1:0] vc_gnt_id;
    logic [3:0] vc_release;
    logic [3:0] vc_busy;
    logic [1:0] bank_in_use;
    logic [1:0] bank_owned;
    logic       protocol_error;

    int   n_compared   = 0;
    int   n_mismatched = 0;
    exp_t sb_q[$];

    shared_bank_port_client dut (
        .clk            (clk),
        .reset          (reset),
        .bank_grant     (bank_grant),
        .bank_ready     (bank_ready),
        .vc_req         (vc_req),
        .vc_gnt         (vc_gnt),
        .vc_gnt_id      (vc_gnt_id),
        .vc_release     (vc_release),
        .vc_busy        (vc_busy),
        .bank_in_use    (bank_in_use),
        .bank_owned     (bank_owned),
        .protocol_error (protocol_error)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_compared++;
        if (obs !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic expect_sig(input string tag, input int sig, input logic [31:0] exp);
        exp_t e;
        e.tag = tag;
        e.sig = sig;
        e.exp = exp;
        sb_q.push_back(e);
    endtask

    function automatic logic [31:0] sample(input int sig);
        case (sig)
            SIG_GNT:   return {31'd0, vc_gnt};
            SIG_ID:    return {30'd0, vc_gnt_id};
            SIG_BUSY:  return {28'd0, vc_busy};
            SIG_INUSE: return {30'd0, bank_in_use};
            SIG_OWNED: return {30'd0, bank_owned};
            default:   return {31'd0, protocol_error};
        endcase
    endfunction

    task automatic drain();
        exp_t e;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check_val(e.tag, sample(e.sig), e.exp);
        end
    endtask

    // Advance past the next rising edge, then check all registered expectations.
    task automatic step();
        @(posedge clk);
        #1;
        drain();
    endtask

    // Check combinational expectations against the inputs just driven.
    task automatic settle();
        #1;
        drain();
    endtask

    task automatic expect_regs(input string tag, input logic [3:0] busy, input logic [1:0] in_use,
                               input logic [1:0] owned, input logic perr);
        expect_sig({tag, "_busy"},   SIG_BUSY,  {28'd0, busy});
        expect_sig({tag, "_in_use"}, SIG_INUSE, {30'd0, in_use});
        expect_sig({tag, "_owned"},  SIG_OWNED, {30'd0, owned});
        expect_sig({tag, "_perr"},   SIG_PERR,  {31'd0, perr});
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset      = 1'b1;
        bank_grant = '0;
        bank_ready = '0;
        vc_req     = 1'b1;
        vc_release = '0;
        step();
        step();
        @(posedge clk); #1;
        reset = 1'b0;

        // Reset state; request held but nothing owned
        expect_regs("rst", 4'b0000, 2'b00, 2'b00, 1'b0);
        expect_sig("rst_gnt", SIG_GNT, 32'd0);
        settle();

        // Bank0 granted to port 0
        vc_req     = 1'b0;
        bank_grant = 10'b00000_00001;
        bank_ready = 2'b11;
        expect_sig("own0", SIG_OWNED, 32'b01);
        step();

        vc_req = 1'b1;
        expect_sig("g0_gnt", SIG_GNT, 32'd1);
        expect_sig("g0_id",  SIG_ID,  32'd0);
        settle();
        expect_regs("g0", 4'b0001, 2'b01, 2'b01, 1'b0);
        step();

        expect_sig("g1_gnt", SIG_GNT, 32'd1);
        expect_sig("g1_id",  SIG_ID,  32'd1);
        settle();
        expect_sig("g1_busy", SIG_BUSY, 32'b0011);
        step();

        // Bank0 full, bank1 idle: no grant; release VC1 in the same cycle
        vc_release = 4'b0010;
        expect_sig("full_gnt", SIG_GNT, 32'd0);
        settle();
        expect_sig("rel1_busy", SIG_BUSY, 32'b0001);
        step();
        vc_release = 4'b0000;
        expect_sig("regnt_gnt", SIG_GNT, 32'd1);
        expect_sig("regnt_id",  SIG_ID,  32'd1);
        settle();
        expect_sig("regnt_busy", SIG_BUSY, 32'b0011);
        step();

        vc_req     = 1'b0;
        vc_release = 4'b0010;
        expect_sig("rel1b_busy", SIG_BUSY, 32'b0001);
        step();

        // Lose ready on bank0 with VC0 busy: drain
        vc_release = 4'b0000;
        bank_ready = 2'b10;
        expect_regs("drain", 4'b0001, 2'b01, 2'b00, 1'b0);
        step();
        vc_req = 1'b1;
        expect_sig("drain_gnt", SIG_GNT, 32'd0);
        settle();
        vc_req     = 1'b0;
        bank_ready = 2'b11;
        vc_release = 4'b0001;
        expect_regs("drained", 4'b0000, 2'b00, 2'b00, 1'b0);
        step();
        // Grant still present: back to OWNED only via IDLE
        vc_release = 4'b0000;
        expect_sig("reown", SIG_OWNED, 32'b01);
        step();

        // Fresh reset, both banks owned, rr_ptr at 0
        reset = 1'b1;
        step();
        reset      = 1'b0;
        bank_grant = 10'b00001_00001;
        expect_sig("both_own", SIG_OWNED, 32'b11);
        step();
        vc_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            expect_sig($sformatf("rr%0d_gnt", i), SIG_GNT, 32'd1);
            expect_sig($sformatf("rr%0d_id", i),  SIG_ID,  i);
            settle();
            @(posedge clk); #1;
        end
        expect_sig("rr4_gnt", SIG_GNT, 32'd0);
        expect_regs("rr_full", 4'b1111, 2'b11, 2'b11, 1'b0);
        settle();
        vc_req = 1'b0;

        // Free bank0 VCs, then release an idle VC
        vc_release = 4'b0011;
        expect_sig("part_busy", SIG_BUSY, 32'b1100);
        step();
        vc_release = 4'b0010;
        expect_regs("perr", 4'b1100, 2'b10, 2'b11, 1'b1);
        step();
        vc_release = 4'b0000;
        expect_sig("perr_sticky", SIG_PERR, 32'd1);
        step();
        expect_sig("perr_sticky2", SIG_PERR, 32'd1);
        step();

        // Mid-operation reset drops everything in one cycle
        reset = 1'b1;
        expect_regs("midrst", 4'b0000, 2'b00, 2'b00, 1'b0);
        step();
        reset = 1'b0;

        // Release while IDLE still flags the error
        bank_grant = '0;
        vc_release = 4'b0001;
        expect_sig("idle_rel_perr", SIG_PERR, 32'd1);
        step();
        vc_release = 4'b0000;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end
endmodule
